// File: rtl/axi4lite_regbank_slave.sv
// AXI4-Lite slave with NUM_REGS read/write registers, independent read and write channels.
// Optional macro AXIL_REGBANK_WSTRB_EN enables per-byte write strobes (otherwise all bytes written).
module axi4lite_regbank_slave #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          s_awaddr,
   input  logic                           s_awvalid,
   output logic                           s_awready,
   input  logic [DATA_WIDTH-1:0]          s_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
   input  logic                           s_wvalid,
   output logic                           s_wready,
   output logic [1:0]                     s_bresp,
   output logic                           s_bvalid,
   input  logic                           s_bready,
   input  logic [ADDR_WIDTH-1:0]          s_araddr,
   input  logic                           s_arvalid,
   output logic                           s_arready,
   output logic [DATA_WIDTH-1:0]          s_rdata,
   output logic [1:0]                     s_rresp,
   output logic                           s_rvalid,
   input  logic                           s_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDXW   = ADDR_WIDTH - LSB;
   localparam logic [IDXW:0] NUM_REGS_L = (IDXW+1)'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;

   wr_state_e             wr_state_q, wr_state_d;
   logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [IDXW-1:0]       awidx_q, awidx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, arready_q, arready_d;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic [IDXW-1:0]       wr_idx, ar_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  commit, wr_ok, ar_ok;

   // Write channel: AW and W are latched independently; the second one to arrive commits.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      awidx_d    = awidx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_idx     = awidx_q;
      wr_data    = wdata_q;
      wr_strb    = wstrb_q;
      commit     = 1'b0;
      wr_ok      = 1'b0;
      regs_d     = regs_q;
      case (wr_state_q)
         WR_IDLE: begin
            if (s_awvalid && awready_q) begin
               aw_got_d = 1'b1;
               awidx_d  = s_awaddr[ADDR_WIDTH-1:LSB];
               wr_idx   = s_awaddr[ADDR_WIDTH-1:LSB];
            end
            if (s_wvalid && wready_q) begin
               w_got_d = 1'b1;
               wdata_d = s_wdata;
               wstrb_d = s_wstrb;
               wr_data = s_wdata;
               wr_strb = s_wstrb;
            end
            if (aw_got_d && w_got_d) begin
               commit     = 1'b1;
               wr_ok      = ({1'b0, wr_idx} < NUM_REGS_L);
               bvalid_d   = 1'b1;
               bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
               aw_got_d   = 1'b0;
               w_got_d    = 1'b0;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (s_bready) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      for (int k = 0; k < NUM_REGS; k++) begin
         if (commit && wr_ok && wr_idx == IDXW'(k)) begin
            for (int b = 0; b < STRB_W; b++) begin
`ifdef AXIL_REGBANK_WSTRB_EN
               if (wr_strb[b]) regs_d[k][b*8 +: 8] = wr_data[b*8 +: 8];
`else
               regs_d[k][b*8 +: 8] = wr_data[b*8 +: 8];
`endif
            end
         end
      end
      awready_d = (wr_state_d == WR_IDLE) && !aw_got_d;
      wready_d  = (wr_state_d == WR_IDLE) && !w_got_d;
   end

`ifndef AXIL_REGBANK_WSTRB_EN
   logic strb_unused;
   assign strb_unused = ^wr_strb;
`endif

   // Read channel samples regs_q, so a same-edge write to the same register reads the old value.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      ar_idx   = s_araddr[ADDR_WIDTH-1:LSB];
      ar_ok    = ({1'b0, ar_idx} < NUM_REGS_L);
      if (s_arvalid && arready_q) begin
         rvalid_d = 1'b1;
         rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
         rdata_d  = '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_ok && ar_idx == IDXW'(k)) rdata_d = regs_q[k];
         end
      end else if (rvalid_q && s_rready) begin
         rvalid_d = 1'b0;
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WR_IDLE;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         awidx_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= 2'b00;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= 2'b00;
         rdata_q    <= '0;
         regs_q     <= '{default: '0};
      end else begin
         wr_state_q <= wr_state_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         awidx_q    <= awidx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         regs_q     <= regs_d;
      end
   end

   generate
      if (LSB > 0) begin : g_lsb
         logic addr_unused;
         assign addr_unused = ^{s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};
      end
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
         assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
      end
   endgenerate

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rresp   = rresp_q;
   assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_axi4lite_regbank_slave.sv
// Directed bench for axi4lite_regbank_slave (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_REGS=3).
// Handshake rule: a transfer happens on a rising edge where valid and ready are both 1.
module tb_axi4lite_regbank_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  s_awaddr, s_araddr;
   logic        s_awvalid, s_awready, s_wvalid, s_wready;
   logic [31:0] s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_bresp, s_rresp;
   logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [95:0] reg_out;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_r1;

   axi4lite_regbank_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .reg_out(reg_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check("wr_bvalid", 96'(s_bvalid), 96'(1));
      check("wr_bresp", 96'(s_bresp), 96'(resp));
      check("wr_awready_busy", 96'(s_awready), 96'(0));
      check("wr_wready_busy", 96'(s_wready), 96'(0));
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check("wr_bvalid_done", 96'(s_bvalid), 96'(0));
      check("wr_awready_back", 96'(s_awready), 96'(1));
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] resp);
      s_araddr = addr;
      s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check("rd_rvalid", 96'(s_rvalid), 96'(1));
      check("rd_rdata", 96'(s_rdata), 96'(data));
      check("rd_rresp", 96'(s_rresp), 96'(resp));
      check("rd_arready_busy", 96'(s_arready), 96'(0));
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
      check("rd_rvalid_done", 96'(s_rvalid), 96'(0));
      check("rd_arready_back", 96'(s_arready), 96'(1));
   endtask

   initial begin
      rst_n = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

      // Reset state and release
      repeat (3) tick();
      check("rst_awready", 96'(s_awready), 96'(0));
      check("rst_wready", 96'(s_wready), 96'(0));
      check("rst_arready", 96'(s_arready), 96'(0));
      check("rst_bvalid", 96'(s_bvalid), 96'(0));
      check("rst_rvalid", 96'(s_rvalid), 96'(0));
      check("rst_bresp", 96'(s_bresp), 96'(0));
      check("rst_rresp", 96'(s_rresp), 96'(0));
      check("rst_rdata", 96'(s_rdata), 96'(0));
      check("rst_reg_out", reg_out, 96'(0));
      rst_n = 1'b1;
      #2;
      check("rel_awready_pre", 96'(s_awready), 96'(0));
      check("rel_arready_pre", 96'(s_arready), 96'(0));
      tick();
      check("rel_awready", 96'(s_awready), 96'(1));
      check("rel_wready", 96'(s_wready), 96'(1));
      check("rel_arready", 96'(s_arready), 96'(1));

      // AW and W together to reg2
      do_write(4'h8, 32'hDEADBEEF, 4'hF, 2'b00);
      check("reg2_after_write", 96'(reg_out[95:64]), 96'(32'hDEADBEEF));
      do_read(4'h8, 32'hDEADBEEF, 2'b00);

      // W three cycles before AW to reg1
      s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
      tick();
      s_wvalid = 1'b0;
      check("wfirst_wready", 96'(s_wready), 96'(0));
      check("wfirst_awready", 96'(s_awready), 96'(1));
      check("wfirst_bvalid0", 96'(s_bvalid), 96'(0));
      tick();
      tick();
      check("wfirst_bvalid_wait", 96'(s_bvalid), 96'(0));
      check("wfirst_reg1_wait", 96'(reg_out[63:32]), 96'(0));
      s_awaddr = 4'h4; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
      check("wfirst_bvalid", 96'(s_bvalid), 96'(1));
      check("wfirst_bresp", 96'(s_bresp), 96'(0));
      check("wfirst_reg1", 96'(reg_out[63:32]), 96'(32'h12345678));
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check("wfirst_bvalid_done", 96'(s_bvalid), 96'(0));
      tick();
      check("wfirst_single_resp", 96'(s_bvalid), 96'(0));

      // Partial strobe write to reg1
`ifdef AXIL_REGBANK_WSTRB_EN
      exp_r1 = 32'h12BB56DD;
`else
      exp_r1 = 32'hAABBCCDD;
`endif
      do_write(4'h4, 32'hAABBCCDD, 4'h5, 2'b00);
      check("strb_reg1", 96'(reg_out[63:32]), 96'(exp_r1));

      // Out-of-range index (0xC -> index 3)
      do_write(4'hC, 32'h55555555, 4'hF, 2'b10);
      check("slverr_reg_out", reg_out, {32'hDEADBEEF, exp_r1, 32'h0});
      do_read(4'hC, 32'h0, 2'b10);

      // Read and write of reg2 on the same edge: read sees the old value
      s_awaddr = 4'h8; s_wdata = 32'h11111111; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_araddr = 4'h8; s_arvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      check("conc_bvalid", 96'(s_bvalid), 96'(1));
      check("conc_rvalid", 96'(s_rvalid), 96'(1));
      check("conc_rdata_old", 96'(s_rdata), 96'(32'hDEADBEEF));
      check("conc_reg2_new", 96'(reg_out[95:64]), 96'(32'h11111111));
      tick();
      tick();
      check("conc_rvalid_hold", 96'(s_rvalid), 96'(1));
      check("conc_rdata_hold", 96'(s_rdata), 96'(32'hDEADBEEF));
      check("conc_arready_hold", 96'(s_arready), 96'(0));
      s_bready = 1'b1; s_rready = 1'b1;
      tick();
      s_bready = 1'b0; s_rready = 1'b0;
      check("conc_bvalid_done", 96'(s_bvalid), 96'(0));
      check("conc_rvalid_done", 96'(s_rvalid), 96'(0));
      do_read(4'h8, 32'h11111111, 2'b00);

      // Back-pressure on B, ignored AW/W while busy, then reset during WR_RESP
      s_awaddr = 4'h0; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awaddr = 4'h4; s_wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 5; i++) begin
         check("hold_bvalid", 96'(s_bvalid), 96'(1));
         check("hold_bresp", 96'(s_bresp), 96'(0));
         check("hold_awready", 96'(s_awready), 96'(0));
         check("hold_wready", 96'(s_wready), 96'(0));
         tick();
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check("hold_reg_out", reg_out, {32'h11111111, exp_r1, 32'h0BADF00D});
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_bvalid", 96'(s_bvalid), 96'(0));
      check("abort_reg_out", reg_out, 96'(0));
      check("abort_awready", 96'(s_awready), 96'(0));
      tick();
      rst_n = 1'b1;
      tick();
      check("post_bvalid", 96'(s_bvalid), 96'(0));
      check("post_awready", 96'(s_awready), 96'(1));
      check("post_reg_out", reg_out, 96'(0));
      tick();
      check("post_no_stale", 96'(s_bvalid), 96'(0));
      do_read(4'h0, 32'h0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi4lite_regbank_slave.md
AXI4LITE_REGBANK_SLAVE -- requirements
Module: axi4lite_regbank_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, byte-address width of AW/AR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter NUM_REGS, default 3, number of implemented registers; legal range 1 to 2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 Ports, in order (ports without a width are 1 bit):
- clk  in  1  single clock, all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid in / s_awready out  write address handshake
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte strobes
- s_wvalid in / s_wready out  write data handshake
- s_bresp  out  2  write response
- s_bvalid out / s_bready in  write response handshake
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid in / s_arready out  read address handshake
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rvalid out / s_rready in  read data handshake
- reg_out  out  NUM_REGS*DATA_WIDTH  all register contents, reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Function
REQ-005 Register index SHALL be addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-006 Index >= NUM_REGS SHALL give response SLVERR (2'b10): write discarded, read data 0; otherwise OKAY (2'b00).
REQ-007 Write FSM states: WR_IDLE, WR_RESP.
- In WR_IDLE: s_awready=1 until AW captured; s_wready=1 until W captured.
- AW and W may arrive in either order or the same cycle.
REQ-008 At the edge where the second of AW/W is captured, the FSM SHALL:
- commit the register update;
- drive s_bresp and s_bvalid=1 from the next cycle;
- enter WR_RESP.
REQ-009 In WR_RESP, s_awready=s_wready=0; s_bvalid and s_bresp SHALL hold stable until s_bready=1, then return to WR_IDLE with captured flags cleared.
REQ-010 Read path:
- s_arready = !s_rvalid.
- On the AR handshake edge, s_rdata/s_rresp are loaded and s_rvalid=1 from the next cycle.
- s_rvalid, s_rdata and s_rresp hold stable until s_rready=1.
REQ-011 Read and write paths SHALL be fully independent and may be active concurrently.
REQ-012 Same register, AR handshake on the same edge as the write commit: the read SHALL return the pre-write value.
REQ-013 Valid/address/data inputs SHALL be ignored while the corresponding ready is 0.
REQ-014 reg_out SHALL reflect register contents, updated one edge after commit, with no combinational path from AXI inputs.
REQ-015 Minimum throughput: one write per 2 cycles with s_bready tied 1; one read per 2 cycles with s_rready tied 1.

Reset
REQ-016 rst_n low SHALL asynchronously force:
- all registers and reg_out to 0;
- s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0;
- write FSM to WR_IDLE with captured AW/W flags cleared.
REQ-017 During reset, s_awready/s_wready/s_arready SHALL be 0; they become 1 on the first edge after rst_n deasserts.
REQ-018 Reset mid-transaction SHALL abort it; no partial register update and no stale response after release.

Configuration
REQ-019 Macro AXIL_REGBANK_WSTRB_EN:
- Defined: each byte lane is written only where s_wstrb bit is 1; all-zero strobe leaves the register unchanged but still returns OKAY.
- Undefined: s_wstrb is ignored and all bytes are written.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_REGS=3)
REQ-020 Benches SHALL cover the following scenarios:
- Reset release: all outputs 0; readys 1 one edge later.
- AW 0x8 and W 0xDEADBEEF, strb 0xF, same cycle -> bvalid next cycle with OKAY; reg_out[95:64]=0xDEADBEEF; read 0x8 returns 0xDEADBEEF, OKAY.
- W before AW by 3 cycles, addr 0x4, data 0x12345678 -> single B response after AW captured; reg1=0x12345678.
- With WSTRB_EN, reg1=0x12345678, write 0xAABBCCDD strb 0x5 -> reg1=0x12BB56DD. Without WSTRB_EN, same write -> 0xAABBCCDD.
- Write and read addr 0xC -> SLVERR on both; rdata 0; reg_out unchanged.
- bready held 0 for 5 cycles -> bvalid/bresp stable, awready 0; rst_n pulsed during WR_RESP -> bvalid 0, registers 0.
